// File: rtl/ccd_line_pkg.sv
`default_nettype none
// ============================================================================
// ccd_line_pkg : shared constants and read-FSM state type for ccd_line_tx
// Revision 1.0
// ============================================================================
package ccd_line_pkg;

   localparam int LINE_W_DEF = 320;
   localparam int DATA_W_DEF = 10;
   localparam int ADDR_W_DEF = $clog2(LINE_W_DEF);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_BLANK  = 2'd2
   } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/line_bank_ram.sv
`default_nettype none
// ============================================================================
// line_bank_ram : simple dual-port RAM, one write and one registered read port
// Revision 1.0
// ============================================================================
module line_bank_ram #(
   parameter int DEPTH = 640,
   parameter int WIDTH = 30,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Read-first: a same-address write in the same cycle returns the old word.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule
`default_nettype wire

// File: rtl/ccd_line_tx.sv
`default_nettype none
// ============================================================================
// ccd_line_tx : two-bank line buffer replayed as DVAL bursts, optional mirror
// Revision 1.0
// ============================================================================
module ccd_line_tx
   import ccd_line_pkg::*;
#(
   parameter int LINE_W = LINE_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int HBLANK = 16
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic [DATA_W-1:0] iR,
   input  logic [DATA_W-1:0] iG,
   input  logic [DATA_W-1:0] iB,
   input  logic              iDVAL,
   input  logic              iMIRROR,
   input  logic              iEN,
   output logic              oFULL,
   output logic [DATA_W-1:0] oCCD_R,
   output logic [DATA_W-1:0] oCCD_G,
   output logic [DATA_W-1:0] oCCD_B,
   output logic              oCCD_DVAL,
   output logic              oLINE_DONE
);

   localparam int CW = $clog2(LINE_W);
   localparam int AW = $clog2(2 * LINE_W);
   localparam int PW = 3 * DATA_W;
   localparam int BW = (HBLANK > 1) ? $clog2(HBLANK) : 1;
   localparam logic [CW-1:0] LAST_COL = CW'(LINE_W - 1);

   logic [CW-1:0] wr_cnt;
   logic          wr_bank;
   logic [1:0]    full;
   logic [1:0]    full_nxt;
   logic [CW-1:0] rd_cnt;
   logic          rd_bank;
   logic          mir;
   logic [BW-1:0] blank_cnt;
   rd_state_t     state;
   rd_state_t     state_nxt;

   logic          rd_issue;
   logic          rd_last;
   logic          rd_start;
   logic          wr_accept;
   logic          wr_last;
   logic [CW-1:0] rd_col;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;
   logic [PW-1:0] rd_data;
   logic          dval_q;
   logic          done_q;

   always_comb begin
      rd_issue  = (state == ST_ACTIVE);
      rd_last   = rd_issue && (rd_cnt == LAST_COL);
      rd_start  = (state == ST_IDLE) && full[rd_bank] && iEN;
      // A bank being freed this cycle may already take the first beat of the next line.
      wr_accept = iDVAL && (!full[wr_bank] || (rd_last && (rd_bank == wr_bank)));
      wr_last   = wr_accept && (wr_cnt == LAST_COL);
      rd_col    = mir ? (LAST_COL - rd_cnt) : rd_cnt;
      // Banks are packed back to back so the RAM is exactly 2*LINE_W deep.
      wr_addr   = wr_bank ? (AW'(LINE_W) + AW'(wr_cnt)) : AW'(wr_cnt);
      rd_addr   = rd_bank ? (AW'(LINE_W) + AW'(rd_col)) : AW'(rd_col);
   end

   always_comb begin
      full_nxt = full;
      if (rd_last) full_nxt[rd_bank] = 1'b0;
      if (wr_last) full_nxt[wr_bank] = 1'b1;
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         wr_cnt  <= '0;
         wr_bank <= 1'b0;
         full    <= 2'b00;
      end else begin
         full <= full_nxt;
         if (wr_accept) begin
            if (wr_last) begin
               wr_cnt  <= '0;
               wr_bank <= ~wr_bank;
            end else begin
               wr_cnt <= wr_cnt + 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (rd_start) state_nxt = ST_ACTIVE;
         ST_ACTIVE: if (rd_last) state_nxt = ST_BLANK;
         ST_BLANK:  if (blank_cnt == '0) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state     <= ST_IDLE;
         rd_cnt    <= '0;
         rd_bank   <= 1'b0;
         mir       <= 1'b0;
         blank_cnt <= '0;
         dval_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state  <= state_nxt;
         dval_q <= rd_issue;
         done_q <= rd_last;
         if (rd_start) begin
            mir    <= iMIRROR;
            rd_cnt <= '0;
         end
         if (rd_issue) begin
            if (rd_last) begin
               rd_cnt    <= '0;
               rd_bank   <= ~rd_bank;
               blank_cnt <= BW'(HBLANK - 1);
            end else begin
               rd_cnt <= rd_cnt + 1'b1;
            end
         end
         if (state == ST_BLANK) blank_cnt <= blank_cnt - 1'b1;
      end
   end

   line_bank_ram #(
      .DEPTH (2 * LINE_W),
      .WIDTH (PW),
      .AW    (AW)
   ) u_ram (
      .clk     (iCLK),
      .wr_en   (wr_accept),
      .wr_addr (wr_addr),
      .wr_data ({iR, iG, iB}),
      .rd_en   (rd_issue),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_comb begin
      oFULL      = full[0] & full[1];
      oCCD_DVAL  = dval_q;
      oLINE_DONE = done_q;
      oCCD_R     = dval_q ? rd_data[3*DATA_W-1:2*DATA_W] : '0;
      oCCD_G     = dval_q ? rd_data[2*DATA_W-1:DATA_W]   : '0;
      oCCD_B     = dval_q ? rd_data[DATA_W-1:0]          : '0;
   end

endmodule
`default_nettype wire

// File: tb/tb_ccd_line_tx.sv
`default_nettype none
// ============================================================================
// tb_ccd_line_tx : directed stimulus against a cycle-timed line-replay model
// Revision 1.0
// ============================================================================
module tb_ccd_line_tx;

   localparam int LINE_W = 320;
   localparam int DATA_W = 10;
   localparam int HBLANK = 16;
   localparam int PERIOD = LINE_W + HBLANK + 1;

   logic              clk;
   logic              rst;
   logic [DATA_W-1:0] in_r, in_g, in_b;
   logic              in_dval, in_mirror, in_en;
   logic              out_full;
   logic [DATA_W-1:0] out_r, out_g, out_b;
   logic              out_dval, out_done;

   ccd_line_tx #(
      .LINE_W (LINE_W),
      .DATA_W (DATA_W),
      .HBLANK (HBLANK)
   ) dut (
      .iCLK       (clk),
      .iRST       (rst),
      .iR         (in_r),
      .iG         (in_g),
      .iB         (in_b),
      .iDVAL      (in_dval),
      .iMIRROR    (in_mirror),
      .iEN        (in_en),
      .oFULL      (out_full),
      .oCCD_R     (out_r),
      .oCCD_G     (out_g),
      .oCCD_B     (out_b),
      .oCCD_DVAL  (out_dval),
      .oLINE_DONE (out_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Model: stored lines as a flat pixel queue, reader timing from the line rules.
   typedef struct packed {
      int          cyc;
      logic [29:0] d;
      logic        last;
   } beat_t;

   logic [29:0] wq[$];
   logic [29:0] cur[$];
   beat_t       sched[$];
   int          cyc      = 0;
   bit          busy     = 0;
   int          free_at  = 0;
   int          ready_at = 0;
   bit          freeing;
   beat_t       b;
   logic        ev, el;
   logic [29:0] ed;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         wq.delete();
         cur.delete();
         sched.delete();
         busy     = 0;
         ready_at = cyc + 1;
      end else begin
         if (!busy && cyc >= ready_at && wq.size() >= LINE_W && in_en) begin
            for (int k = 0; k < LINE_W; k++) begin
               b.cyc  = cyc + 1 + k;
               b.d    = wq[in_mirror ? (LINE_W - 1 - k) : k];
               b.last = (k == LINE_W - 1);
               sched.push_back(b);
            end
            busy     = 1;
            free_at  = cyc + LINE_W;
            ready_at = cyc + LINE_W + HBLANK + 1;
         end
         freeing = busy && (cyc == free_at);
         if (in_dval && (wq.size() < 2 * LINE_W || freeing)) begin
            cur.push_back({in_r, in_g, in_b});
            if (cur.size() == LINE_W) begin
               foreach (cur[i]) wq.push_back(cur[i]);
               cur.delete();
            end
         end
         if (freeing) begin
            repeat (LINE_W) void'(wq.pop_front());
            busy = 0;
         end
      end
      #1;
      if (sched.size() > 0 && sched[0].cyc == cyc) begin
         b  = sched.pop_front();
         ev = 1'b1;
         ed = b.d;
         el = b.last;
      end else begin
         ev = 1'b0;
         ed = '0;
         el = 1'b0;
      end
      check("dval", 32'(out_dval), 32'(ev));
      check("pixel", 32'({out_r, out_g, out_b}), 32'(ed));
      check("line_done", 32'(out_done), 32'(el));
      check("full", 32'(out_full), 32'(wq.size() == 2 * LINE_W));
   end

   // Output monitor: per-line summary for the literal expectations.
   int negcnt = 0, nlines = 0, full_cnt = 0, cur_beat = 0;
   bit in_line = 0;
   int t_first, t_g, t_start;
   int line_first_r[$], line_last_r[$], line_g[$], line_start[$], line_end[$];

   always @(negedge clk) begin
      negcnt++;
      if (out_full) full_cnt++;
      if (out_dval) begin
         if (!in_line) begin
            in_line  = 1;
            cur_beat = 0;
            t_first  = int'(out_r);
            t_g      = int'(out_g);
            t_start  = negcnt;
         end
         cur_beat++;
         if (out_done) begin
            line_first_r.push_back(t_first);
            line_last_r.push_back(int'(out_r));
            line_g.push_back(t_g);
            line_start.push_back(t_start);
            line_end.push_back(negcnt);
            nlines++;
            in_line = 0;
         end
      end else if (in_line) begin
         in_line = 0;
      end
   end

   task automatic write_line(input int tag);
      for (int c = 0; c < LINE_W; c++) begin
         @(negedge clk);
         in_dval = 1'b1;
         in_r    = DATA_W'(c);
         in_g    = DATA_W'(tag);
         in_b    = DATA_W'(c + tag);
      end
      @(negedge clk);
      in_dval = 1'b0;
   endtask

   task automatic wait_lines(input int target, input int limit, input string name);
      int k = 0;
      while (nlines < target && k < limit) begin
         @(negedge clk);
         k++;
      end
      check(name, 32'(nlines), 32'(target));
   endtask

   task automatic wait_beat(input int n, input string name);
      int k = 0;
      while (!(in_line && cur_beat >= n) && k < 2000) begin
         @(negedge clk);
         k++;
      end
      check(name, 32'(in_line && cur_beat >= n), 32'd1);
   endtask

   int lat, base, dv, fc0;

   initial begin
      rst = 1'b1; in_dval = 1'b0; in_mirror = 1'b0; in_en = 1'b0;
      in_r = '0; in_g = '0; in_b = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset_dval", 32'(out_dval), 32'd0);
      check("reset_full", 32'(out_full), 32'd0);

      // Forward replay
      in_en = 1'b1;
      base  = nlines;
      write_line(5);
      lat = 1;
      while (!out_dval && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      check("fwd_latency", 32'(lat), 32'd3);
      wait_lines(base + 1, 2 * PERIOD, "fwd_line");
      check("fwd_first_r", 32'(line_first_r[base]), 32'd0);
      check("fwd_last_r", 32'(line_last_r[base]), 32'd319);
      check("fwd_len", 32'(line_end[base] - line_start[base] + 1), 32'(LINE_W));
      repeat (HBLANK + 4) @(negedge clk);

      // Mirrored replay
      in_mirror = 1'b1;
      base = nlines;
      write_line(6);
      wait_lines(base + 1, 2 * PERIOD, "mir_line");
      check("mir_first_r", 32'(line_first_r[base]), 32'd319);
      check("mir_last_r", 32'(line_last_r[base]), 32'd0);
      in_mirror = 1'b0;
      repeat (HBLANK + 4) @(negedge clk);

      // Overflow: third line must be dropped entirely
      in_en = 1'b0;
      base = nlines;
      write_line(1);
      write_line(2);
      check("ovf_full_after_2", 32'(out_full), 32'd1);
      write_line(3);
      check("ovf_full_after_3", 32'(out_full), 32'd1);
      in_en = 1'b1;
      wait_lines(base + 2, 3 * PERIOD, "ovf_two_lines");
      repeat (PERIOD + 10) @(negedge clk);
      check("ovf_no_third", 32'(nlines), 32'(base + 2));
      check("ovf_line1_g", 32'(line_g[base]), 32'd1);
      check("ovf_line2_g", 32'(line_g[base + 1]), 32'd2);
      check("ovf_gap", 32'(line_start[base + 1] - line_end[base] - 1), 32'(HBLANK + 1));
      check("ovf_full_clear", 32'(out_full), 32'd0);

      // Mirror toggled mid-line: next line only
      base = nlines;
      write_line(20);
      fork
         write_line(21);
         begin
            wait_beat(100, "tog_beat100");
            in_mirror = 1'b1;
         end
      join
      wait_lines(base + 2, 3 * PERIOD, "tog_lines");
      in_mirror = 1'b0;
      check("tog_a_first", 32'(line_first_r[base]), 32'd0);
      check("tog_a_last", 32'(line_last_r[base]), 32'd319);
      check("tog_b_first", 32'(line_first_r[base + 1]), 32'd319);
      check("tog_b_last", 32'(line_last_r[base + 1]), 32'd0);
      repeat (HBLANK + 4) @(negedge clk);

      // Reset at beat 150
      base = nlines;
      write_line(30);
      wait_beat(150, "rst_beat150");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_dval", 32'(out_dval), 32'd0);
      check("rst_full", 32'(out_full), 32'd0);
      dv = 0;
      repeat (2 * LINE_W) begin
         @(negedge clk);
         if (out_dval) dv++;
      end
      check("rst_no_beats", 32'(dv), 32'd0);
      check("rst_no_line", 32'(nlines), 32'(base));
      write_line(7);
      wait_lines(base + 1, 2 * PERIOD, "rst_fresh_line");
      check("rst_fresh_first", 32'(line_first_r[base]), 32'd0);
      check("rst_fresh_last", 32'(line_last_r[base]), 32'd319);
      check("rst_fresh_g", 32'(line_g[base]), 32'd7);
      repeat (HBLANK + 4) @(negedge clk);

      // Streaming with 20 idle cycles between input lines
      base = nlines;
      fc0  = full_cnt;
      for (int i = 0; i < 4; i++) begin
         write_line(10 + i);
         repeat (20) @(negedge clk);
      end
      wait_lines(base + 4, 3 * PERIOD, "stream_lines");
      check("stream_never_full", 32'(full_cnt - fc0), 32'd0);
      for (int i = 0; i < 4; i++) begin
         check("stream_order", 32'(line_g[base + i]), 32'(10 + i));
      end
      repeat (10) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
